// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer slice.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_XLEN  = 32;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Entry fields are sized by SB_XLEN; instantiations keep XLEN equal to it.
  typedef struct packed {
    logic [SB_XLEN-1:0] addr;
    logic [SB_XLEN-1:0] wdata;
    logic [3:0]         be;
  } store_entry_t;

endpackage

// File: rtl/store_align.sv
// Lane alignment of a store and detection of illegal size/offset combinations.
module store_align import store_buffer_pkg::*; #(
  parameter int unsigned XLEN = SB_XLEN
) (
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [3:0]      i_we,
  output logic [XLEN-1:0] o_addr,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_be,
  output logic            o_misalign
);

  logic [1:0] w_off;

  assign w_off   = i_addr[1:0];
  assign o_addr  = {i_addr[XLEN-1:2], 2'b00};
  assign o_be    = i_we << w_off;
  assign o_wdata = i_wdata << {w_off, 3'b000};

  always_comb begin
    o_misalign = 1'b1;
    case (i_we)
      BE_BYTE: o_misalign = 1'b0;
      BE_HALF: o_misalign = w_off[0];
      BE_WORD: o_misalign = (w_off != 2'b00);
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between execute and data memory, with load hazard detection.
module store_buffer import store_buffer_pkg::*; #(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned XLEN  = SB_XLEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [XLEN-1:0]              st_addr,
  input  logic [XLEN-1:0]              st_wdata,
  input  logic [3:0]                   st_we,
  input  logic                         ld_check,
  input  logic [XLEN-1:0]              ld_addr,
  output logic                         ld_hazard,
  output logic                         mem_valid,
  input  logic                         mem_ready,
  output logic [XLEN-1:0]              mem_addr,
  output logic [XLEN-1:0]              mem_wdata,
  output logic [3:0]                   mem_be,
  output logic                         misalign,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  store_entry_t    r_mem [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_misalign;

  logic [XLEN-1:0] w_addr;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_be;
  logic            w_mis;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_hazard;

  store_align #(.XLEN(XLEN)) u_align (
    .i_addr     (st_addr),
    .i_wdata    (st_wdata),
    .i_we       (st_we),
    .o_addr     (w_addr),
    .o_wdata    (w_wdata),
    .o_be       (w_be),
    .o_misalign (w_mis)
  );

  assign st_ready  = (r_count != CW'(DEPTH));
  assign mem_valid = (r_count != '0);
  assign w_accept  = st_valid & st_ready;
  assign w_push    = w_accept & ~w_mis;
  assign w_pop     = mem_valid & mem_ready;

  assign mem_addr  = r_mem[r_rptr].addr;
  assign mem_wdata = r_mem[r_rptr].wdata;
  assign mem_be    = r_mem[r_rptr].be;
  assign count     = r_count;
  assign misalign  = r_misalign;
  assign ld_hazard = w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept & w_mis;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{addr: w_addr, wdata: w_wdata, be: w_be};
  end

  // A slot is occupied when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    w_hazard = 1'b0;
    if (ld_check) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((CW'(PTRW'(PTRW'(i) - r_rptr)) < r_count) &&
            (r_mem[i].addr[XLEN-1:2] == ld_addr[XLEN-1:2]))
          w_hazard = 1'b1;
      end
      if (w_push && (w_addr[XLEN-1:2] == ld_addr[XLEN-1:2]))
        w_hazard = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomised checks of store_buffer against a queue-based scoreboard.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_we;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [2:0]  count;

  store_entry_t q[$];
  int m_cnt;
  logic m_mis;
  int errors;
  int checks;

  store_buffer #(.DEPTH(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_wdata  (st_wdata),
    .st_we     (st_we),
    .ld_check  (ld_check),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .misalign  (misalign),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks outputs at the negedge, advances the model, then moves to just after the next posedge.
  task automatic cycle();
    logic         acc;
    logic         mis;
    logic         push;
    logic         pop;
    logic         hz;
    logic [1:0]   off;
    store_entry_t e;
    @(negedge clk);
    chk("count", 32'(count), 32'(m_cnt));
    chk("st_ready", 32'(st_ready), 32'(m_cnt != 4));
    chk("mem_valid", 32'(mem_valid), 32'(m_cnt != 0));
    chk("misalign", 32'(misalign), 32'(m_mis));
    if (m_cnt != 0) begin
      chk("head_addr", mem_addr, q[0].addr);
      chk("head_wdata", mem_wdata, q[0].wdata);
      chk("head_be", 32'(mem_be), 32'(q[0].be));
    end
    off     = st_addr[1:0];
    acc     = st_valid && (m_cnt != 4);
    case (st_we)
      4'b0001: mis = 1'b0;
      4'b0011: mis = off[0];
      4'b1111: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    e.addr  = {st_addr[31:2], 2'b00};
    e.be    = 4'(st_we << off);
    e.wdata = st_wdata << (8 * off);
    push    = acc && !mis;
    pop     = (m_cnt != 0) && mem_ready;
    hz      = 1'b0;
    if (ld_check) begin
      foreach (q[k]) if (q[k].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
      if (push && e.addr[31:2] == ld_addr[31:2]) hz = 1'b1;
    end
    chk("ld_hazard", 32'(ld_hazard), 32'(hz));
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    m_cnt = q.size();
    m_mis = acc && mis;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_we    = we;
  endtask

  initial begin
    errors = 0; checks = 0; m_cnt = 0; m_mis = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_we = '0;
    ld_check = 1'b0; ld_addr = '0; mem_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store at offset 3
    mem_ready = 1'b1;
    store(32'h103, 32'hAB, 4'b0001);
    cycle();
    st_valid = 1'b0;
    chk("sb_valid", 32'(mem_valid), 32'd1);
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_be", 32'(mem_be), 32'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    cycle();

    // Misaligned half-word store is dropped with a one-cycle pulse
    store(32'h201, 32'h1234, 4'b0011);
    cycle();
    st_valid = 1'b0;
    chk("sh_misalign", 32'(misalign), 32'd1);
    chk("sh_count", 32'(count), 32'd0);
    chk("sh_mem_valid", 32'(mem_valid), 32'd0);
    cycle();
    chk("sh_pulse_end", 32'(misalign), 32'd0);

    // Fill, refuse a fifth, pop-only when full, then push+pop
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111);
      cycle();
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(st_ready), 32'd0);
    store(32'h410, 32'hDEAD_BEEF, 4'b1111);
    cycle();
    chk("fifth_rejected", 32'(count), 32'd4);
    mem_ready = 1'b1;
    store(32'h414, 32'h5555_0001, 4'b1111);
    cycle();
    chk("pop_only_count", 32'(count), 32'd3);
    store(32'h418, 32'h5555_0002, 4'b0011);
    cycle();
    chk("push_pop_count", 32'(count), 32'd3);
    st_valid = 1'b0;
    for (int k = 0; k < 10 && m_cnt != 0; k++) cycle();
    chk("drain1", 32'(count), 32'd0);

    // Load hazard against buffered and same-cycle stores
    mem_ready = 1'b0;
    store(32'h300, 32'h0BAD_F00D, 4'b1111);
    cycle();
    st_valid = 1'b0;
    ld_check = 1'b1;
    ld_addr  = 32'h302;
    #1 chk("hz_match", 32'(ld_hazard), 32'd1);
    cycle();
    ld_addr = 32'h304;
    #1 chk("hz_other_word", 32'(ld_hazard), 32'd0);
    cycle();
    store(32'h501, 32'h77, 4'b0001);
    ld_addr = 32'h500;
    #1 chk("hz_same_cycle", 32'(ld_hazard), 32'd1);
    cycle();
    st_valid = 1'b0;
    ld_check = 1'b0;
    #1 chk("hz_no_check", 32'(ld_hazard), 32'd0);
    cycle();
    mem_ready = 1'b1;
    for (int k = 0; k < 10 && m_cnt != 0; k++) cycle();
    chk("drain2", 32'(count), 32'd0);
    ld_check = 1'b1;
    ld_addr  = 32'h302;
    #1 chk("hz_after_drain", 32'(ld_hazard), 32'd0);
    cycle();
    ld_check = 1'b0;

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_addr   = 32'h700 + 32'($urandom_range(0, 15));
      st_wdata  = $urandom;
      case ($urandom_range(0, 4))
        0: st_we = 4'b0001;
        1: st_we = 4'b0011;
        2: st_we = 4'b1111;
        3: st_we = 4'b0000;
        default: st_we = 4'b0110;
      endcase
      mem_ready = 1'($urandom_range(0, 1));
      ld_check  = 1'($urandom_range(0, 1));
      ld_addr   = 32'h700 + 32'($urandom_range(0, 15));
      cycle();
    end
    st_valid = 1'b0;
    ld_check = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 10 && m_cnt != 0; k++) cycle();
    chk("drain3", 32'(count), 32'd0);

    // Asynchronous reset with pending stores and a pending misalign pulse
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      store(32'h600 + 32'(4 * i), 32'hAAAA_0000 + 32'(i), 4'b1111);
      cycle();
    end
    store(32'h60E, 32'h1, 4'b1111);
    cycle();
    st_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_misalign", 32'(misalign), 32'd0);
    chk("arst_st_ready", 32'(st_ready), 32'd1);
    q.delete();
    m_cnt = 0;
    m_mis = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
